// File: rtl/sampler_pkg.sv
// -----------------------------------------------------------------------------
// sampler_pkg : candidate layout, PRNG step and FSM encoding for the harvester
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package sampler_pkg;

    localparam int VEC_W = 185;

    // Packed candidate layout, var_0 at the LSBs.
    localparam int VAR_LSB [10] = '{0, 16, 38, 42, 70, 89, 107, 126, 140, 156};
    localparam int VAR_W   [10] = '{16, 22, 4, 28, 19, 18, 19, 14, 16, 29};

    localparam logic [63:0] ZERO_SEED_SUB = 64'h9E37_79B9_7F4A_7C15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    function automatic logic [63:0] xorshift64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo : synchronous first-word fall-through FIFO with full/empty flags
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    // Push is gated on the start-of-cycle full flag: no bypass when a pop frees a slot.
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/sample_harvester.sv
// -----------------------------------------------------------------------------
// sample_harvester : drives PRNG candidates into the checker, harvests hits
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sample_harvester
    import sampler_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_TRIES  = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      seed,
    input  logic [15:0]      target_count,
    output logic [VEC_W-1:0] cand_vec,
    input  logic             cand_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      tries_count,
    output logic [15:0]      accepted_count
);

    localparam int          HI_W        = VEC_W - 128;
    localparam logic [31:0] MAX_TRIES_C = 32'(MAX_TRIES);

    state_e           state_q,   state_d;
    logic [63:0]      prng_q,    prng_d;
    logic [VEC_W-1:0] cand_q,    cand_d;
    logic [15:0]      target_q,  target_d;
    logic [31:0]      tries_q,   tries_d;
    logic [15:0]      acc_q,     acc_d;
    logic             timeout_q, timeout_d;
    logic             fresh_q,   fresh_d;

    logic [63:0]      w_s1, w_s2, w_s3;
    logic [VEC_W-1:0] w_cand;
    logic [31:0]      w_tries_inc, w_tries_eff;
    logic [15:0]      w_acc_inc;
    logic             w_push;
    logic             w_full;
    logic             w_empty;

    assign w_s1   = xorshift64(prng_q);
    assign w_s2   = xorshift64(w_s1);
    assign w_s3   = xorshift64(w_s2);
    assign w_cand = {w_s3[HI_W-1:0], w_s2, w_s1};

    assign w_tries_inc = (&tries_q) ? tries_q : tries_q + 32'd1;
    // A stalled candidate was already counted on its first CHECK cycle.
    assign w_tries_eff = fresh_q ? w_tries_inc : tries_q;
    assign w_acc_inc   = (&acc_q) ? acc_q : acc_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        prng_d    = prng_q;
        cand_d    = cand_q;
        target_d  = target_q;
        tries_d   = tries_q;
        acc_d     = acc_q;
        timeout_d = timeout_q;
        fresh_d   = fresh_q;
        w_push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    prng_d    = (seed == 64'd0) ? ZERO_SEED_SUB : seed;
                    target_d  = target_count;
                    tries_d   = '0;
                    acc_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = (target_count == 16'd0) ? ST_FIN : ST_GEN;
                end
            end
            ST_GEN: begin
                cand_d  = w_cand;
                prng_d  = w_s3;
                fresh_d = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                tries_d = w_tries_eff;
                fresh_d = 1'b0;
                if (cand_ok) begin
                    if (!w_full) begin
                        w_push  = 1'b1;
                        acc_d   = w_acc_inc;
                        state_d = (w_acc_inc == target_q) ? ST_FIN : ST_GEN;
                    end
                end else if (w_tries_eff == MAX_TRIES_C) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    state_d = ST_GEN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prng_q    <= '0;
            cand_q    <= '0;
            target_q  <= '0;
            tries_q   <= '0;
            acc_q     <= '0;
            timeout_q <= 1'b0;
            fresh_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prng_q    <= prng_d;
            cand_q    <= cand_d;
            target_q  <= target_d;
            tries_q   <= tries_d;
            acc_q     <= acc_d;
            timeout_q <= timeout_d;
            fresh_q   <= fresh_d;
        end
    end

    sample_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .din_i   (cand_q),
        .pop_i   (out_ready),
        .dout_o  (out_data),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign cand_vec       = cand_q;
    assign out_valid      = !w_empty;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign timeout        = timeout_q;
    assign tries_count    = tries_q;
    assign accepted_count = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_harvester.sv
// -----------------------------------------------------------------------------
// tb_sample_harvester : directed + randomized runs against a run-level model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_sample_harvester;
    import sampler_pkg::*;

    localparam int DEPTH = 8;
    localparam int MAXT  = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [63:0]      seed;
    logic [15:0]      target_count;
    logic [VEC_W-1:0] cand_vec;
    logic             cand_ok;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_data;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [31:0]      tries_count;
    logic [15:0]      accepted_count;

    int               n_total = 0;
    int               n_bad   = 0;
    int               ok_mode = 1;
    logic [7:0]       ok_thr  = 8'd0;
    logic [VEC_W-1:0] exp_q [$];

    sample_harvester #(
        .FIFO_DEPTH (DEPTH),
        .MAX_TRIES  (MAXT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .seed           (seed),
        .target_count   (target_count),
        .cand_vec       (cand_vec),
        .cand_ok        (cand_ok),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .tries_count    (tries_count),
        .accepted_count (accepted_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Stub checker: never, always, or low byte below a threshold.
    function automatic logic stub_ok(input logic [VEC_W-1:0] c, input int mode, input logic [7:0] thr);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return (c[7:0] < thr);
        endcase
    endfunction

    assign cand_ok = stub_ok(cand_vec, ok_mode, ok_thr);

    function automatic logic [63:0] xs(input logic [63:0] v);
        logic [63:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 7);
        x = x ^ (x << 17);
        return x;
    endfunction

    function automatic logic [VEC_W-1:0] first_cand(input logic [63:0] st);
        logic [63:0]  a, b, c;
        logic [191:0] w;
        a = xs(st);
        b = xs(a);
        c = xs(b);
        w = {c, b, a};
        return w[VEC_W-1:0];
    endfunction

    // Whole-run model: the try sequence, queued hits and final counters.
    task automatic model_run(input logic [63:0] sd, input int tgt, input int mode, input logic [7:0] thr,
                             output int m_tries, output int m_acc, output logic m_to);
        logic [63:0]      st;
        logic [VEC_W-1:0] cand;
        st      = (sd == 64'd0) ? 64'h9E3779B97F4A7C15 : sd;
        m_tries = 0;
        m_acc   = 0;
        m_to    = 1'b0;
        while (tgt != 0) begin
            cand = first_cand(st);
            st   = xs(xs(xs(st)));
            m_tries++;
            if (stub_ok(cand, mode, thr)) begin
                m_acc++;
                exp_q.push_back(cand);
                if (m_acc == tgt) break;
            end else if (m_tries == MAXT) begin
                m_to = 1'b1;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_eq("pop_expected", 192'(exp_q.size() != 0), 192'(1));
            if (exp_q.size() != 0) check_eq("pop_data", 192'(out_data), 192'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [63:0] sd, input int tgt);
        seed         = sd;
        target_count = 16'(tgt);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        repeat (DEPTH + 3) tick();
        check_eq({tag, "_drained"}, 192'(out_valid), 192'(0));
        check_eq({tag, "_q_empty"}, 192'(exp_q.size()), 192'(0));
    endtask

    // Run with out_ready=1: no FIFO stalls, so the run lasts exactly two cycles per try.
    task automatic run_timed(input string tag, input logic [63:0] sd, input int tgt, input int mode, input logic [7:0] thr);
        int   m_tries, m_acc, k;
        logic m_to;
        model_run(sd, tgt, mode, thr, m_tries, m_acc, m_to);
        ok_mode = mode;
        ok_thr  = thr;
        pulse_start(sd, tgt);
        k = 0;
        while (!done && k < 2 * m_tries + 20) begin
            tick();
            k++;
        end
        check_eq({tag, "_done_cycle"}, 192'(k), 192'(2 * m_tries));
        check_eq({tag, "_tries"}, 192'(tries_count), 192'(m_tries));
        check_eq({tag, "_accepted"}, 192'(accepted_count), 192'(m_acc));
        check_eq({tag, "_timeout"}, 192'(timeout), 192'(m_to));
        tick();
        check_eq({tag, "_done_pulse"}, 192'(done), 192'(0));
        check_eq({tag, "_idle"}, 192'(busy), 192'(0));
        check_eq({tag, "_timeout_sticky"}, 192'(timeout), 192'(m_to));
        drain_check(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   m_tries, m_acc, k;
        logic m_to;
        logic [63:0] sd;

        rst_n        = 1'b0;
        start        = 1'b0;
        seed         = '0;
        target_count = '0;
        out_ready    = 1'b1;
        repeat (3) tick();
        check_eq("rst_out_valid", 192'(out_valid), 192'(0));
        check_eq("rst_busy", 192'(busy), 192'(0));
        check_eq("rst_done", 192'(done), 192'(0));
        check_eq("rst_timeout", 192'(timeout), 192'(0));
        check_eq("rst_cand_vec", 192'(cand_vec), 192'(0));
        check_eq("rst_tries", 192'(tries_count), 192'(0));
        check_eq("rst_accepted", 192'(accepted_count), 192'(0));
        rst_n = 1'b1;
        tick();

        run_timed("all_ok", 64'h1, 4, 1, 8'd0);
        run_timed("none_ok", {$urandom, $urandom}, 5, 0, 8'd0);
        run_timed("zero_target", {$urandom, $urandom}, 0, 1, 8'd0);

        // Stall: FIFO fills with out_ready low, ninth candidate waits in CHECK.
        out_ready = 1'b0;
        sd = {$urandom, $urandom};
        model_run(sd, 10, 1, 8'd0, m_tries, m_acc, m_to);
        ok_mode = 1;
        pulse_start(sd, 10);
        k = 0;
        while (tries_count != 32'd9 && k < 100) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check_eq("stall_tries", 192'(tries_count), 192'(9));
        check_eq("stall_busy", 192'(busy), 192'(1));
        check_eq("stall_accepted", 192'(accepted_count), 192'(DEPTH));
        check_eq("stall_valid", 192'(out_valid), 192'(1));
        out_ready = 1'b1;
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        check_eq("stall_done_seen", 192'(done), 192'(1));
        check_eq("stall_final_accepted", 192'(accepted_count), 192'(m_acc));
        check_eq("stall_final_tries", 192'(tries_count), 192'(m_tries));
        drain_check("stall");

        // Zero seed behaves like the substitute seed.
        model_run(64'd0, 1, 1, 8'd0, m_tries, m_acc, m_to);
        ok_mode = 1;
        pulse_start(64'd0, 1);
        tick();
        check_eq("seed0_cand", 192'(cand_vec), 192'(first_cand(64'h9E3779B97F4A7C15)));
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        check_eq("seed0_done_seen", 192'(done), 192'(1));
        drain_check("seed0");

        // Reset in the middle of a stalled run.
        out_ready = 1'b0;
        sd = {$urandom, $urandom};
        model_run(sd, 10, 1, 8'd0, m_tries, m_acc, m_to);
        pulse_start(sd, 10);
        k = 0;
        while (accepted_count != 16'd5 && k < 100) begin
            tick();
            k++;
        end
        check_eq("midrst_reached5", 192'(accepted_count), 192'(5));
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check_eq("midrst_valid", 192'(out_valid), 192'(0));
        check_eq("midrst_busy", 192'(busy), 192'(0));
        check_eq("midrst_tries", 192'(tries_count), 192'(0));
        check_eq("midrst_accepted", 192'(accepted_count), 192'(0));
        check_eq("midrst_cand", 192'(cand_vec), 192'(0));
        check_eq("midrst_out_data", 192'(out_data), 192'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        run_timed("after_rst", sd, 3, 1, 8'd0);

        for (int r = 0; r < 24; r++) begin
            int         mode;
            logic [7:0] thr;
            mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : 2;
            thr  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(64, 255));
            run_timed("rand", {$urandom, $urandom}, int'($urandom_range(0, 5)), mode, thr);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
